if_fetch_bridge: RTL

Fetch-side responder for the PC register. It accepts the `pc`/`ce` fetch address stream, runs one word read per address on a ready/valid instruction-memory bus, and returns the instruction word to the IF/ID stage. While the requested word is not yet available, it raises a stall request to the pipeline controller, which holds `pc` through `stall[0]`. It sits between the PC register, the IF/ID register, the controller and the instruction memory port.

---
 rtl/if_fetch_bridge.sv | 107 ++++++++++
 1 files changed

// File: rtl/if_fetch_bridge.sv
// Fetch-side responder: one-entry instruction buffer in front of a ready/valid
// instruction memory, raising stallreq until the word for pc is buffered.
module if_fetch_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic [DATA_W-1:0] inst_o,
  output logic              stallreq,
  output logic              fetch_err,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              buf_valid_q, buf_valid_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;

  logic hit;
  logic misal;

  assign hit       = buf_valid_q && (buf_addr_q == pc);
  assign misal     = ce && (pc[1:0] != 2'b00);
  assign fetch_err = misal;
  assign stallreq  = ce && !misal && !hit;
  assign inst_o    = (ce && hit && !misal) ? buf_data_q : '0;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;

    // Disabled fetch invalidates the buffer, but a landing word still fills it.
    if (!ce) buf_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (ce && !misal && !hit && !flush) begin
          mem_addr_d = pc;
          mem_req_d  = 1'b1;
          state_d    = BUSY;
        end
      end
      BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
          if (!flush) begin
            buf_addr_d  = mem_addr_q;
            buf_data_d  = mem_rdata;
            buf_valid_d = 1'b1;
          end
        end else if (flush) begin
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        // The bus transfer must finish; its data is simply dropped.
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    if (flush) buf_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end

endmodule
